// File: rtl/fp_host_ctrl.sv
// Host-side sequencer for fp_pipeline: loads IMEM/DMEM, runs for N cycles, streams encoded DMEM out.
// Readback datapath is built only when FP_HOST_READBACK_EN is defined.
module fp_host_ctrl #(
    parameter int unsigned RUN_W     = 24,
    parameter int unsigned ENC_DEPTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_sel,
    input  logic [31:0]      cmd_data,
    output logic [31:0]      imem_data,
    output logic [11:0]      imem_addr,
    output logic             imem_we,
    output logic [15:0]      dmem_data_scalar,
    output logic [5:0]       dmem_addr_scalar,
    output logic             dmem_we_external_scalar,
    output logic [15:0]      dmem_data_batch,
    output logic [8:0]       dmem_addr_batch,
    output logic             dmem_we_external_batch,
    output logic [8:0]       dmem_addr_encoded,
    output logic             dmem_re_external_encoded,
    input  logic [15:0]      dmem_out_encoded,
    output logic             pipe_en,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [15:0]      rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] OpWrite    = 2'd0;
    localparam logic [1:0] OpRun      = 2'd1;
    localparam logic [1:0] OpReadback = 2'd2;
    localparam logic [1:0] OpRewind   = 2'd3;

`ifdef FP_HOST_READBACK_EN
    typedef enum logic [2:0] {StIdle, StRun, StRdAddr, StRdCap, StRdWait} state_e;
    localparam logic [8:0] LastIdx = 9'(ENC_DEPTH - 1);
    logic [8:0]  idx_q, idx_d, enc_addr_q, enc_addr_d;
    logic        enc_re_q, enc_re_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [15:0] rd_data_q, rd_data_d;
`else
    typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

    state_e           state_q, state_d;
    logic [11:0]      imem_cnt_q, imem_cnt_d, imem_addr_q, imem_addr_d;
    logic [5:0]       sc_cnt_q, sc_cnt_d, sc_addr_q, sc_addr_d;
    logic [8:0]       bt_cnt_q, bt_cnt_d, bt_addr_q, bt_addr_d;
    logic [31:0]      imem_data_q, imem_data_d;
    logic [15:0]      sc_data_q, sc_data_d, bt_data_q, bt_data_d;
    logic             imem_we_q, imem_we_d, sc_we_q, sc_we_d, bt_we_q, bt_we_d;
    logic             pipe_en_q, pipe_en_d, err_q, err_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

    always_comb begin
        state_d     = state_q;
        imem_cnt_d  = imem_cnt_q;
        sc_cnt_d    = sc_cnt_q;
        bt_cnt_d    = bt_cnt_q;
        imem_addr_d = imem_addr_q;
        sc_addr_d   = sc_addr_q;
        bt_addr_d   = bt_addr_q;
        imem_data_d = imem_data_q;
        sc_data_d   = sc_data_q;
        bt_data_d   = bt_data_q;
        imem_we_d   = 1'b0;
        sc_we_d     = 1'b0;
        bt_we_d     = 1'b0;
        pipe_en_d   = pipe_en_q;
        err_d       = err_q;
        run_cnt_d   = run_cnt_q;
`ifdef FP_HOST_READBACK_EN
        idx_d       = idx_q;
        enc_addr_d  = enc_addr_q;
        enc_re_d    = 1'b0;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OpWrite: begin
                            unique case (cmd_sel)
                                2'd0: begin
                                    imem_we_d   = 1'b1;
                                    imem_addr_d = imem_cnt_q;
                                    imem_data_d = cmd_data;
                                    imem_cnt_d  = imem_cnt_q + 12'd1;
                                end
                                2'd1: begin
                                    sc_we_d   = 1'b1;
                                    sc_addr_d = sc_cnt_q;
                                    sc_data_d = cmd_data[15:0];
                                    sc_cnt_d  = sc_cnt_q + 6'd1;
                                end
                                2'd2: begin
                                    bt_we_d   = 1'b1;
                                    bt_addr_d = bt_cnt_q;
                                    bt_data_d = cmd_data[15:0];
                                    bt_cnt_d  = bt_cnt_q + 9'd1;
                                end
                                default: err_d = 1'b1;
                            endcase
                        end
                        OpRun: begin
                            if (cmd_data[RUN_W-1:0] != '0) begin
                                state_d   = StRun;
                                pipe_en_d = 1'b1;
                                run_cnt_d = cmd_data[RUN_W-1:0];
                            end
                        end
                        OpReadback: begin
`ifdef FP_HOST_READBACK_EN
                            state_d    = StRdAddr;
                            idx_d      = 9'd0;
                            enc_addr_d = 9'd0;
                            enc_re_d   = 1'b1;
`endif
                        end
                        default: begin
                            imem_cnt_d = '0;
                            sc_cnt_d   = '0;
                            bt_cnt_d   = '0;
                            err_d      = 1'b0;
                        end
                    endcase
                end
            end
            StRun: begin
                // run_cnt_q holds cycles still to go including the current one
                if (run_cnt_q == RUN_W'(1)) begin
                    state_d   = StIdle;
                    pipe_en_d = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q - RUN_W'(1);
                end
            end
`ifdef FP_HOST_READBACK_EN
            StRdAddr: state_d = StRdCap;
            StRdCap: begin
                rd_data_d  = dmem_out_encoded;
                rd_valid_d = 1'b1;
                rd_last_d  = (idx_q == LastIdx);
                state_d    = StRdWait;
            end
            StRdWait: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d      = idx_q + 9'd1;
                        enc_addr_d = idx_q + 9'd1;
                        enc_re_d   = 1'b1;
                        state_d    = StRdAddr;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            imem_cnt_q  <= '0;
            sc_cnt_q    <= '0;
            bt_cnt_q    <= '0;
            imem_addr_q <= '0;
            sc_addr_q   <= '0;
            bt_addr_q   <= '0;
            imem_data_q <= '0;
            sc_data_q   <= '0;
            bt_data_q   <= '0;
            imem_we_q   <= 1'b0;
            sc_we_q     <= 1'b0;
            bt_we_q     <= 1'b0;
            pipe_en_q   <= 1'b0;
            err_q       <= 1'b0;
            run_cnt_q   <= '0;
`ifdef FP_HOST_READBACK_EN
            idx_q       <= '0;
            enc_addr_q  <= '0;
            enc_re_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            imem_cnt_q  <= imem_cnt_d;
            sc_cnt_q    <= sc_cnt_d;
            bt_cnt_q    <= bt_cnt_d;
            imem_addr_q <= imem_addr_d;
            sc_addr_q   <= sc_addr_d;
            bt_addr_q   <= bt_addr_d;
            imem_data_q <= imem_data_d;
            sc_data_q   <= sc_data_d;
            bt_data_q   <= bt_data_d;
            imem_we_q   <= imem_we_d;
            sc_we_q     <= sc_we_d;
            bt_we_q     <= bt_we_d;
            pipe_en_q   <= pipe_en_d;
            err_q       <= err_d;
            run_cnt_q   <= run_cnt_d;
`ifdef FP_HOST_READBACK_EN
            idx_q       <= idx_d;
            enc_addr_q  <= enc_addr_d;
            enc_re_q    <= enc_re_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
`endif
        end
    end

    assign cmd_ready               = (state_q == StIdle);
    assign busy                    = (state_q != StIdle);
    assign err                     = err_q;
    assign pipe_en                 = pipe_en_q;
    assign imem_we                 = imem_we_q;
    assign imem_addr               = imem_addr_q;
    assign imem_data               = imem_data_q;
    assign dmem_we_external_scalar = sc_we_q;
    assign dmem_addr_scalar        = sc_addr_q;
    assign dmem_data_scalar        = sc_data_q;
    assign dmem_we_external_batch  = bt_we_q;
    assign dmem_addr_batch         = bt_addr_q;
    assign dmem_data_batch         = bt_data_q;

`ifdef FP_HOST_READBACK_EN
    assign dmem_addr_encoded        = enc_addr_q;
    assign dmem_re_external_encoded = enc_re_q;
    assign rd_valid                 = rd_valid_q;
    assign rd_last                  = rd_last_q;
    assign rd_data                  = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd                = ^{dmem_out_encoded, rd_ready};
    assign dmem_addr_encoded        = '0;
    assign dmem_re_external_encoded = 1'b0;
    assign rd_valid                 = 1'b0;
    assign rd_last                  = 1'b0;
    assign rd_data                  = '0;
`endif

endmodule

// File: tb/tb_fp_host_ctrl.sv
// Scoreboard bench for fp_host_ctrl: stimulus pushes expectations, negedge monitors pop and compare.
module tb_fp_host_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [1:0]  cmd_sel = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [31:0] imem_data;
    logic [11:0] imem_addr;
    logic        imem_we;
    logic [15:0] dmem_data_scalar;
    logic [5:0]  dmem_addr_scalar;
    logic        dmem_we_external_scalar;
    logic [15:0] dmem_data_batch;
    logic [8:0]  dmem_addr_batch;
    logic        dmem_we_external_batch;
    logic [8:0]  dmem_addr_encoded;
    logic        dmem_re_external_encoded;
    logic [15:0] dmem_out_encoded = 16'd0;
    logic        pipe_en;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        err;

    fp_host_ctrl dut (
        .clk                      (clk),
        .reset                    (reset),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_op                   (cmd_op),
        .cmd_sel                  (cmd_sel),
        .cmd_data                 (cmd_data),
        .imem_data                (imem_data),
        .imem_addr                (imem_addr),
        .imem_we                  (imem_we),
        .dmem_data_scalar         (dmem_data_scalar),
        .dmem_addr_scalar         (dmem_addr_scalar),
        .dmem_we_external_scalar  (dmem_we_external_scalar),
        .dmem_data_batch          (dmem_data_batch),
        .dmem_addr_batch          (dmem_addr_batch),
        .dmem_we_external_batch   (dmem_we_external_batch),
        .dmem_addr_encoded        (dmem_addr_encoded),
        .dmem_re_external_encoded (dmem_re_external_encoded),
        .dmem_out_encoded         (dmem_out_encoded),
        .pipe_en                  (pipe_en),
        .rd_valid                 (rd_valid),
        .rd_ready                 (rd_ready),
        .rd_data                  (rd_data),
        .rd_last                  (rd_last),
        .busy                     (busy),
        .err                      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [15:0] data;
        logic        last;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  runq[$];

    logic [11:0] m_imem = '0;
    logic [5:0]  m_sc = '0;
    logic [8:0]  m_bt = '0;
    logic        m_err = 1'b0;
    bit          ignore_run = 1'b0;
    bit          rd_rand = 1'b0;

    // Encoded DMEM model: registered read returning addr + 0x100
    always @(posedge clk) begin
        if (dmem_re_external_encoded) dmem_out_encoded <= 16'(dmem_addr_encoded) + 16'h100;
    end

    always @(posedge clk) begin
        #1;
        rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        int  n;
        wr_t e;
        n = int'(imem_we) + int'(dmem_we_external_scalar) + int'(dmem_we_external_batch);
        if (n != 0) begin
            chk("strobe_count", n, 1);
            if (wq.size() == 0) begin
                chk("strobe_unexpected_pending", 0, 1);
            end else begin
                e = wq.pop_front();
                unique case (e.sel)
                    2'd0: begin
                        chk("imem_we", imem_we, 1);
                        chk("imem_addr", imem_addr, e.addr);
                        chk("imem_data", imem_data, e.data);
                    end
                    2'd1: begin
                        chk("scalar_we", dmem_we_external_scalar, 1);
                        chk("scalar_addr", dmem_addr_scalar, e.addr);
                        chk("scalar_data", dmem_data_scalar, e.data[15:0]);
                    end
                    default: begin
                        chk("batch_we", dmem_we_external_batch, 1);
                        chk("batch_addr", dmem_addr_batch, e.addr);
                        chk("batch_data", dmem_data_batch, e.data[15:0]);
                    end
                endcase
            end
        end
    end

    // pipe_en monitor: measures high-run length and checks cmd_ready/busy during it
    int run_len = 0;
    always @(negedge clk) begin
        if (pipe_en) begin
            run_len++;
            chk("cmd_ready_low_in_run", cmd_ready, 0);
        end else if (run_len != 0) begin
            if (ignore_run) begin
                run_len = 0;
            end else if (runq.size() == 0) begin
                chk("run_unexpected_len", run_len, 0);
            end else begin
                chk("run_len", run_len, runq.pop_front());
                chk("cmd_ready_after_run", cmd_ready, 1);
            end
            run_len = 0;
        end
    end

    // Readback stream monitor
    logic [15:0] held;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        rd_t e;
        if (rd_valid) begin
            if (stalled) chk("rd_data_stable", rd_data, held);
            if (rd_ready) begin
                stalled = 1'b0;
                if (rq.size() == 0) begin
                    chk("rd_unexpected_word", rd_data, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_last", rd_last, e.last);
                end
            end else begin
                stalled = 1'b1;
                held    = rd_data;
            end
        end else begin
            stalled = 1'b0;
            if (rd_last) chk("rd_last_without_valid", rd_last, 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] sel, input logic [31:0] data);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = data;
        while (!cmd_ready && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
        if (op == 2'd0) begin
            unique case (sel)
                2'd0: begin wq.push_back('{2'd0, m_imem, data}); m_imem++; end
                2'd1: begin wq.push_back('{2'd1, 12'(m_sc), data}); m_sc++; end
                2'd2: begin wq.push_back('{2'd2, 12'(m_bt), data}); m_bt++; end
                default: m_err = 1'b1;
            endcase
        end else if (op == 2'd3) begin
            m_imem = '0;
            m_sc   = '0;
            m_bt   = '0;
            m_err  = 1'b0;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("err", err, m_err);
    endtask

    task automatic wait_idle(input int bound);
        int g = 0;
        while (busy && g < bound) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("idle_within_bound", busy, 0);
    endtask

    initial begin
        #2;
        chk("rst_imem_we", imem_we, 0);
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_addrs", {imem_addr, dmem_addr_scalar, dmem_addr_batch}, 0);
        chk("rst_data", imem_data | 32'(dmem_data_scalar) | 32'(dmem_data_batch), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        // Back-to-back IMEM writes at 0,1,2
        send(2'd0, 2'd0, 32'hA);
        send(2'd0, 2'd0, 32'hB);
        send(2'd0, 2'd0, 32'hC);

        // 65 scalar writes: last one wraps to address 0
        for (int i = 0; i < 65; i++) send(2'd0, 2'd1, 32'h1230 + 32'(i));
        chk("scalar_wrap_model", 32'(m_sc), 1);

        // Illegal target, then rewind clears err and counters
        send(2'd0, 2'd3, 32'hDEAD);
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        send(2'd3, 2'd0, 32'h0);
        send(2'd0, 2'd2, 32'h5A5A);
        send(2'd0, 2'd0, 32'h77);

        // RUN 5 then RUN 0
        runq.push_back(5);
        send(2'd1, 2'd0, 32'd5);
        wait_idle(50);
        repeat (2) @(posedge clk);
        #1;
        send(2'd1, 2'd0, 32'd0);
        chk("run0_busy", busy, 0);
        chk("run0_pipe_en", pipe_en, 0);
        repeat (3) @(posedge clk);
        #1;

`ifdef FP_HOST_READBACK_EN
        for (int i = 0; i < 512; i++) rq.push_back('{16'(i) + 16'h100, i == 511});
        rd_rand = 1'b1;
        send(2'd2, 2'd0, 32'h0);
        wait_idle(20000);
        rd_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rd_all_words_seen", rq.size(), 0);
`else
        send(2'd2, 2'd0, 32'h0);
        chk("rd_noop_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rd_noop_valid", rd_valid, 0);
`endif

        // Reset during RUN 100 at cycle 10
        send(2'd1, 2'd0, 32'd100);
        repeat (9) @(posedge clk);
        #3;
        ignore_run = 1'b1;
        reset = 1'b0;
        #1;
        chk("async_pipe_en_drop", pipe_en, 0);
        chk("async_busy_drop", busy, 0);
        m_imem = '0;
        m_sc   = '0;
        m_bt   = '0;
        m_err  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_pipe_en", pipe_en, 0);
        repeat (2) @(posedge clk);
        #1;
        ignore_run = 1'b0;
        send(2'd0, 2'd0, 32'hFACE);
        send(2'd0, 2'd1, 32'h0BEE);
        repeat (3) @(posedge clk);
        #1;
        chk("write_queue_drained", wq.size(), 0);
        chk("run_queue_drained", runq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_host_ctrl.md
# fp_host_ctrl

Host-side sequencer that sits directly upstream of `fp_pipeline` and drives all of its external memory and control ports. It accepts a simple command stream (write word, run, readback, rewind), auto-increments per-memory load addresses, asserts `pipe_en` for an exact programmed cycle count, and streams the encoded data memory back out with valid/ready backpressure. It replaces the bench-side load/run/save sequencing with synthesizable logic.

## Interface

Parameters:
- `RUN_W`, 24: width of the run-cycle count taken from `cmd_data`.
- `ENC_DEPTH`, 512: words read back from encoded DMEM. Must be ≤ 512.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  2  0 = WRITE, 1 = RUN, 2 = READBACK, 3 = REWIND.
- `cmd_sel`  in  2  WRITE target: 0 = IMEM, 1 = scalar DMEM, 2 = batch DMEM, 3 = illegal.
- `cmd_data`  in  32  WRITE payload; RUN count in `[RUN_W-1:0]`.
- `imem_data`, `imem_addr`, `imem_we`  out  32/12/1  to `fp_pipeline` IMEM port.
- `dmem_data_scalar`, `dmem_addr_scalar`, `dmem_we_external_scalar`  out  16/6/1  scalar port.
- `dmem_data_batch`, `dmem_addr_batch`, `dmem_we_external_batch`  out  16/9/1  batch port.
- `dmem_addr_encoded`, `dmem_re_external_encoded`  out  9/1  encoded read port.
- `dmem_out_encoded`  in  16  encoded read data; valid 1 cycle after address/re.
- `pipe_en`  out  1  pipeline enable.
- `rd_valid`, `rd_ready`, `rd_data`, `rd_last`  out/in/out/out  1/1/16/1  readback stream.
- `busy`  out  1  FSM not in IDLE.
- `err`  out  1  sticky: illegal WRITE target seen.

## Operation

- FSM states: IDLE, RUN, RD_ADDR, RD_CAP, RD_WAIT. `cmd_ready = (state == IDLE)`.
- WRITE: one-cycle write strobe on the selected port in the cycle after acceptance. Data is `cmd_data` truncated to port width (low bits). The address is that target's load counter, which increments after the strobe and wraps at 4096, 64, or 512. Stays in IDLE, so back-to-back WRITEs give one word per cycle.
- WRITE with `cmd_sel` = 3: no strobe, no counter change, `err` set.
- REWIND: all three load counters := 0, `err` := 0.
- RUN with count N: N = 0 stays in IDLE with no `pipe_en`. Otherwise go to RUN; `pipe_en` = 1 for exactly N cycles starting the cycle after acceptance, then return to IDLE.
- READBACK: index := 0.
  - RD_ADDR drives `dmem_addr_encoded` = index and `dmem_re_external_encoded` = 1.
  - RD_CAP registers `dmem_out_encoded` into `rd_data`.
  - RD_WAIT holds `rd_valid` = 1 and `rd_data` stable until `rd_ready`.
  - On handshake: if index == ENC_DEPTH−1, return to IDLE; else index++ and go to RD_ADDR.
- `rd_last` = 1 with `rd_valid` on the final word only.
- The encoded write port is not driven; `fp_pipeline` data/enable inputs for encoded writes are tied 0 at the integration level.
- Commands arriving while busy are held off by `cmd_ready` = 0. No command is lost or reordered.

## Timing

- Reset (async assert, sync release): state = IDLE, all load counters = 0, index = 0, all `*_we`/`re`/`pipe_en`/`rd_valid`/`rd_last`/`err` = 0, all address and data outputs = 0, `busy` = 0. `cmd_ready` = 1 after release.
- Reset mid-RUN drops `pipe_en` immediately. Reset mid-readback drops `rd_valid` immediately. No resumption in either case.
- WRITE latency: accept at edge k; strobe, address and data valid from edge k to k+1.
- RUN: accept at edge k; `pipe_en` high from edge k through edge k+N; `busy` drops at edge k+N.
- Readback: at least 3 cycles per word. `rd_data` is stable from `rd_valid` rise to the handshake.
- All outputs are registered.

## Configuration

- `FP_HOST_READBACK_EN` defined: READBACK behaves as above.
- Not defined:
  - READBACK is accepted and treated as a no-op.
  - RD_* states, the index counter and the `rd_data` register are not built.
  - `rd_valid`, `rd_last`, `rd_data`, `dmem_addr_encoded` and `dmem_re_external_encoded` are tied to 0.

## Test plan

- Three WRITEs to IMEM with data 0xA, 0xB, 0xC back-to-back -> `imem_we` high for 3 consecutive cycles at addresses 0, 1, 2 with those values; IMEM counter = 3.
- 65 WRITEs to scalar DMEM -> the 65th strobe lands at address 0 (wrap); `err` stays 0.
- WRITE with `cmd_sel` = 3 -> no strobe, `err` = 1; then REWIND -> `err` = 0 and next batch write goes to address 0.
- RUN with N = 5 -> `pipe_en` high exactly 5 cycles, `cmd_ready` low for those 5; RUN with N = 0 -> no `pipe_en` pulse.
- READBACK against a memory model holding addr+0x100, with `rd_ready` toggled randomly -> 512 words 0x100..0x2FF in order, `rd_last` only on 0x2FF, `rd_data` stable while stalled.
- Assert `reset` low during a RUN with N = 100 at cycle 10 -> `pipe_en` falls asynchronously; after release, IDLE with `cmd_ready` = 1 and counters at 0.
